// File: rtl/tv80_alu16_pkg.sv
// ============================================================================
// Module  : tv80_alu16_pkg
// Purpose : Shared types and constants for the 16-bit two-pass ALU sequencer.
//           Defines the 16-bit operation and sequencer state encodings, the
//           8-bit ALU opcodes the sequencer drives, flag bit positions, and a
//           helper that builds the F_In value for the high-byte pass.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tv80_alu16_pkg;

  // 16-bit operation requested by microcode
  typedef enum logic [1:0] {
    ADD16 = 2'd0,
    ADC16 = 2'd1,
    SBC16 = 2'd2,
    INC16 = 2'd3
  } alu16_op_e;

  // Sequencer state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // 8-bit ALU_Op encodings used by the sequencer
  localparam logic [3:0] c_alu_add = 4'd0;
  localparam logic [3:0] c_alu_adc = 4'd1;
  localparam logic [3:0] c_alu_sbc = 4'd3;

  // Flag register bit positions (S Z Y H X P/V N C)
  localparam int unsigned c_flag_c = 0;
  localparam int unsigned c_flag_n = 1;
  localparam int unsigned c_flag_p = 2;
  localparam int unsigned c_flag_x = 3;
  localparam int unsigned c_flag_h = 4;
  localparam int unsigned c_flag_y = 5;
  localparam int unsigned c_flag_z = 6;
  localparam int unsigned c_flag_s = 7;

  // High-byte pass sees the original flags except Z and C, which come from
  // the low-byte pass so the ALU can chain carry and merge zero across bytes.
  function automatic logic [7:0] hi_pass_fin(input logic [7:0] f_in,
                                             input logic       lo_z,
                                             input logic       lo_c);
    logic [7:0] f;
    f           = f_in;
    f[c_flag_z] = lo_z;
    f[c_flag_c] = lo_c;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tv80_alu16_seq.sv
// ============================================================================
// Module  : tv80_alu16_seq
// Purpose : Two-pass sequencer driving an external 8-bit tv80_alu to perform
//           16-bit ADD/ADC/SBC (HL,rr) as a low-byte pass then a high-byte
//           pass, chaining carry and merging zero between them.
// Config  : TV80_ALU16_INCDEC_EN - when defined, op=3 executes INC16 through
//           the ALU; otherwise op=3 completes immediately with err.
// Ports   : i_clk            core clock, rising edge
//           i_reset_n        synchronous active-low reset
//           i_start          request, accepted in IDLE or DONE
//           i_op[1:0]        0=ADD16 1=ADC16 2=SBC16 3=INC16
//           i_opa[15:0]      operand A (HL)
//           i_opb[15:0]      operand B (rr)
//           i_f_in[7:0]      flag register at start
//           o_busy           high during the LO and HI passes
//           o_done           one-cycle completion pulse
//           o_err            with done, unsupported operation
//           o_result[15:0]   registered 16-bit result
//           o_f_out[7:0]     registered final flags
//           o_alu_op[3:0]    to ALU ALU_Op
//           o_alu_arith16    to ALU Arith16
//           o_alu_z16        to ALU Z16
//           o_alu_busa[7:0]  to ALU BusA
//           o_alu_busb[7:0]  to ALU BusB
//           o_alu_fin[7:0]   to ALU F_In
//           i_alu_q[7:0]     from ALU Q
//           i_alu_fout[7:0]  from ALU F_Out
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tv80_alu16_seq
  import tv80_alu16_pkg::*;
#(
  parameter int MODE = 3
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [15:0] i_opa,
  input  logic [15:0] i_opb,
  input  logic [7:0]  i_f_in,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_result,
  output logic [7:0]  o_f_out,
  output logic [3:0]  o_alu_op,
  output logic        o_alu_arith16,
  output logic        o_alu_z16,
  output logic [7:0]  o_alu_busa,
  output logic [7:0]  o_alu_busb,
  output logic [7:0]  o_alu_fin,
  input  logic [7:0]  i_alu_q,
  input  logic [7:0]  i_alu_fout
);

  // MODE selects behaviour inside the sibling ALU instance only; the
  // sequencing itself is identical for every mode.
  if (MODE != 3) begin : g_mode_other
  end

  seq_state_e r_state;
  seq_state_e w_state_nxt;

  alu16_op_e   r_op;
  logic [15:0] r_opa;
  logic [15:0] r_opb;
  logic [7:0]  r_f_in;
  logic [7:0]  r_lo_q;
  logic        r_lo_z;
  logic        r_lo_c;
  logic [15:0] r_result;
  logic [7:0]  r_f_out;
  logic        r_err;

  logic        w_accept;
  logic        w_op_unsupported;
  logic        w_done;

  logic [3:0]  w_alu_op;
  logic        w_alu_arith16;
  logic        w_alu_z16;
  logic [7:0]  w_alu_busa;
  logic [7:0]  w_alu_busb;
  logic [7:0]  w_alu_fin;

`ifdef TV80_ALU16_INCDEC_EN
  assign w_op_unsupported = 1'b0;
`else
  assign w_op_unsupported = (alu16_op_e'(i_op) == INC16);
`endif

  // A new job may start while the previous one is still showing done
  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          // Unsupported ops skip the ALU and finish on the next cycle
          w_state_nxt = w_op_unsupported ? DONE : LO;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LO:      w_state_nxt = HI;
      HI:      w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand latch, inter-pass storage and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_op     <= ADD16;
      r_opa    <= '0;
      r_opb    <= '0;
      r_f_in   <= '0;
      r_lo_q   <= '0;
      r_lo_z   <= 1'b0;
      r_lo_c   <= 1'b0;
      r_result <= '0;
      r_f_out  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= alu16_op_e'(i_op);
        r_opa  <= i_opa;
        r_opb  <= i_opb;
        r_f_in <= i_f_in;
        r_err  <= w_op_unsupported;
        if (w_op_unsupported) begin
          r_result <= i_opa;
          r_f_out  <= i_f_in;
        end
      end

      if (r_state == LO) begin
        r_lo_q <= i_alu_q;
        r_lo_z <= i_alu_fout[c_flag_z];
        r_lo_c <= i_alu_fout[c_flag_c];
      end

      if (r_state == HI) begin
        r_result <= {i_alu_q, r_lo_q};
        // INC rr leaves the flag register untouched
        r_f_out  <= (r_op == INC16) ? r_f_in : i_alu_fout;
      end
    end
  end

  // --------------------------------------------------------------------------
  // ALU drive: only active during the two passes, zero otherwise
  // --------------------------------------------------------------------------
  always_comb begin
    w_alu_op      = '0;
    w_alu_arith16 = 1'b0;
    w_alu_z16     = 1'b0;
    w_alu_busa    = '0;
    w_alu_busb    = '0;
    w_alu_fin     = '0;
    case (r_state)
      LO: begin
        w_alu_busa = r_opa[7:0];
        w_alu_busb = r_opb[7:0];
        w_alu_fin  = r_f_in;
        case (r_op)
          ADD16: begin
            // Arith16 keeps S/Z/P from F_In, as ADD HL,rr requires
            w_alu_op      = c_alu_add;
            w_alu_arith16 = 1'b1;
          end
          ADC16:   w_alu_op = c_alu_adc;
          SBC16:   w_alu_op = c_alu_sbc;
          default: begin
`ifdef TV80_ALU16_INCDEC_EN
            w_alu_op      = c_alu_add;
            w_alu_arith16 = 1'b1;
            w_alu_busb    = 8'h01;
`endif
          end
        endcase
      end
      HI: begin
        w_alu_busa = r_opa[15:8];
        w_alu_busb = r_opb[15:8];
        w_alu_fin  = hi_pass_fin(r_f_in, r_lo_z, r_lo_c);
        case (r_op)
          ADD16: begin
            w_alu_op      = c_alu_adc;
            w_alu_arith16 = 1'b1;
          end
          ADC16: begin
            // Z16 ANDs this byte's zero with the low byte's Z in F_In
            w_alu_op  = c_alu_adc;
            w_alu_z16 = 1'b1;
          end
          SBC16: begin
            w_alu_op  = c_alu_sbc;
            w_alu_z16 = 1'b1;
          end
          default: begin
`ifdef TV80_ALU16_INCDEC_EN
            w_alu_op      = c_alu_adc;
            w_alu_arith16 = 1'b1;
            w_alu_busb    = 8'h00;
`endif
          end
        endcase
      end
      default: begin
      end
    endcase
  end

  assign w_done        = (r_state == DONE);
  assign o_busy        = (r_state == LO) || (r_state == HI);
  assign o_done        = w_done;
  assign o_err         = w_done && r_err;
  assign o_result      = r_result;
  assign o_f_out       = r_f_out;
  assign o_alu_op      = w_alu_op;
  assign o_alu_arith16 = w_alu_arith16;
  assign o_alu_z16     = w_alu_z16;
  assign o_alu_busa    = w_alu_busa;
  assign o_alu_busb    = w_alu_busb;
  assign o_alu_fin     = w_alu_fin;

endmodule

`default_nettype wire
